// File: rtl/btb_update_queue.sv
// Circular queue between the two execute-pipe branch units and the BTB update
// port: accepts up to two resolution reports per cycle, issues one per cycle.
module btb_update_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stallreq,
  input  logic        flush,
  input  logic        in0_valid,
  input  logic [31:0] in0_pc,
  input  logic        in0_mispred,
  input  logic        in0_taken,
  input  logic [31:0] in0_target,
  input  logic        in0_type,
  input  logic        in1_valid,
  input  logic [31:0] in1_pc,
  input  logic        in1_mispred,
  input  logic        in1_taken,
  input  logic [31:0] in1_target,
  input  logic        in1_type,
  output logic        in_ready,
  output logic [31:0] update_pc,
  output logic        pred_flag,
  output logic        pred_true,
  output logic        real_direct,
  output logic [31:0] real_address,
  output logic        update_type,
  output logic [CW-1:0] q_count,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);

  // entry layout: {pc[66:35], mispred[34], taken[33], target[32:1], type[0]}
  logic [66:0]   mem_r [DEPTH];
  logic [AW-1:0] wp_r;
  logic [AW-1:0] rp_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;

  logic [CW-1:0] free_s;
  logic          in_ready_s;
  logic          accept_s;
  logic          pop_s;
  logic          drop_s;
  logic          nonempty_s;
  logic [AW-1:0] wp1_s;
  logic [66:0]   e0_s;
  logic [66:0]   e1_s;
  logic [66:0]   head_s;
  logic          wr0_en_s;
  logic          wr1_en_s;
  logic [66:0]   wr0_data_s;
  logic [66:0]   wr1_data_s;
  logic [CW-1:0] push_s;

  assign free_s     = CW'(DEPTH) - count_r;
  assign in_ready_s = (free_s >= CW'(2));
  assign nonempty_s = (count_r != '0);
  assign accept_s   = ~flush & in_ready_s;
  assign pop_s      = nonempty_s & ~stallreq & ~flush;
  assign drop_s     = ~flush & ~in_ready_s & (in0_valid | in1_valid);
  assign wp1_s      = wp_r + AW'(1);
  assign e0_s       = {in0_pc, in0_mispred, in0_taken, in0_target, in0_type};
  assign e1_s       = {in1_pc, in1_mispred, in1_taken, in1_target, in1_type};
  assign head_s     = mem_r[rp_r];

  // Route the accepted reports onto the two write slots, oldest first.
  always_comb begin
    wr0_en_s   = 1'b0;
    wr1_en_s   = 1'b0;
    wr0_data_s = e0_s;
    wr1_data_s = e1_s;
    push_s     = '0;
    if (accept_s) begin
      if (in0_valid) begin
        wr0_en_s = 1'b1;
        if (in1_valid) begin
          wr1_en_s = 1'b1;
          push_s   = CW'(2);
        end else begin
          push_s   = CW'(1);
        end
      end else if (in1_valid) begin
        wr0_en_s   = 1'b1;
        wr0_data_s = e1_s;
        push_s     = CW'(1);
      end else begin
        push_s = '0;
      end
    end else begin
      push_s = '0;
    end
  end

  // Queue storage, pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wp_r       <= '0;
      rp_r       <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (drop_s) overflow_r <= 1'b1;
      if (flush) begin
        wp_r    <= '0;
        rp_r    <= '0;
        count_r <= '0;
      end else begin
        if (wr0_en_s) mem_r[wp_r]  <= wr0_data_s;
        if (wr1_en_s) mem_r[wp1_s] <= wr1_data_s;
        wp_r    <= wp_r + push_s[AW-1:0];
        if (pop_s) rp_r <= rp_r + AW'(1);
        count_r <= count_r + push_s - {{(CW-1){1'b0}}, pop_s};
      end
    end
  end

  // Strobes are gated by flush so a discarded head is never reported.
  assign pred_flag    = nonempty_s & ~flush &  head_s[34];
  assign pred_true    = nonempty_s & ~flush & ~head_s[34];
  assign update_pc    = head_s[66:35];
  assign real_direct  = head_s[33];
  assign real_address = head_s[32:1];
  assign update_type  = head_s[0];
  assign q_count      = count_r;
  assign in_ready     = in_ready_s;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed self-checking bench for btb_update_queue (DEPTH=4).
module tb_btb_update_queue;

  logic        clk;
  logic        resetn;
  logic        stallreq;
  logic        flush;
  logic        in0_valid, in1_valid;
  logic [31:0] in0_pc, in1_pc, in0_target, in1_target;
  logic        in0_mispred, in1_mispred, in0_taken, in1_taken, in0_type, in1_type;
  logic        in_ready;
  logic [31:0] update_pc;
  logic        pred_flag, pred_true, real_direct, update_type, overflow;
  logic [31:0] real_address;
  logic [2:0]  q_count;

  int tests = 0;
  int fails = 0;

  btb_update_queue #(.DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .stallreq(stallreq), .flush(flush),
    .in0_valid(in0_valid), .in0_pc(in0_pc), .in0_mispred(in0_mispred),
    .in0_taken(in0_taken), .in0_target(in0_target), .in0_type(in0_type),
    .in1_valid(in1_valid), .in1_pc(in1_pc), .in1_mispred(in1_mispred),
    .in1_taken(in1_taken), .in1_target(in1_target), .in1_type(in1_type),
    .in_ready(in_ready), .update_pc(update_pc), .pred_flag(pred_flag),
    .pred_true(pred_true), .real_direct(real_direct), .real_address(real_address),
    .update_type(update_type), .q_count(q_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic [31:0] pc, input logic m, input logic t,
                      input logic [31:0] tg, input logic ty);
    in0_valid = 1'b1; in0_pc = pc; in0_mispred = m; in0_taken = t;
    in0_target = tg; in0_type = ty;
  endtask

  task automatic set1(input logic [31:0] pc, input logic m, input logic t,
                      input logic [31:0] tg, input logic ty);
    in1_valid = 1'b1; in1_pc = pc; in1_mispred = m; in1_taken = t;
    in1_target = tg; in1_type = ty;
  endtask

  task automatic idle();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; stallreq = 1'b0; flush = 1'b0;
    idle();
    set0(32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    set1(32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle();
    #3;
    check("rst_q_count", 32'(q_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_pred_flag", 32'(pred_flag), 32'd0);
    check("rst_pred_true", 32'(pred_true), 32'd0);
    check("rst_update_pc", update_pc, 32'h0);
    check("rst_real_address", real_address, 32'h0);
    check("rst_overflow", 32'(overflow), 32'd0);
    #14 resetn = 1'b1;
    tick();

    // single report
    set0(32'h1000, 1'b1, 1'b1, 32'h2000, 1'b0);
    tick(); idle();
    check("single_pred_flag", 32'(pred_flag), 32'd1);
    check("single_pred_true", 32'(pred_true), 32'd0);
    check("single_update_pc", update_pc, 32'h1000);
    check("single_real_address", real_address, 32'h2000);
    check("single_real_direct", 32'(real_direct), 32'd1);
    check("single_update_type", 32'(update_type), 32'd0);
    check("single_q_count", 32'(q_count), 32'd1);
    tick();
    check("single_after_pred_flag", 32'(pred_flag), 32'd0);
    check("single_after_q_count", 32'(q_count), 32'd0);

    // ordered dual report
    set0(32'h100, 1'b0, 1'b1, 32'h200, 1'b1);
    set1(32'h104, 1'b1, 1'b0, 32'h300, 1'b0);
    tick(); idle();
    check("dual_q_count", 32'(q_count), 32'd2);
    check("dual0_update_pc", update_pc, 32'h100);
    check("dual0_pred_true", 32'(pred_true), 32'd1);
    check("dual0_pred_flag", 32'(pred_flag), 32'd0);
    check("dual0_update_type", 32'(update_type), 32'd1);
    tick();
    check("dual1_update_pc", update_pc, 32'h104);
    check("dual1_pred_flag", 32'(pred_flag), 32'd1);
    check("dual1_pred_true", 32'(pred_true), 32'd0);
    check("dual1_real_address", real_address, 32'h300);
    tick();
    check("dual_empty_q_count", 32'(q_count), 32'd0);

    // fill and overflow under stall
    stallreq = 1'b1;
    set0(32'h10, 1'b0, 1'b0, 32'h0, 1'b0); set1(32'h14, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    check("fill1_q_count", 32'(q_count), 32'd2);
    check("fill1_in_ready", 32'(in_ready), 32'd1);
    set0(32'h18, 1'b0, 1'b0, 32'h0, 1'b0); set1(32'h1C, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    check("fill2_q_count", 32'(q_count), 32'd4);
    check("fill2_in_ready", 32'(in_ready), 32'd0);
    check("fill2_overflow", 32'(overflow), 32'd0);
    set0(32'h20, 1'b0, 1'b0, 32'h0, 1'b0); set1(32'h24, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(); idle();
    check("fill3_q_count", 32'(q_count), 32'd4);
    check("fill3_overflow", 32'(overflow), 32'd1);
    stallreq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_update_pc", i), update_pc, 32'h10 + 32'(4 * i));
      check($sformatf("drain%0d_pred_true", i), 32'(pred_true), 32'd1);
      tick();
    end
    check("drain_q_count", 32'(q_count), 32'd0);
    check("drain_pred_true", 32'(pred_true), 32'd0);
    check("drain_in_ready", 32'(in_ready), 32'd1);

    // stall hold
    set0(32'h500, 1'b1, 1'b0, 32'h600, 1'b1);
    tick(); idle();
    stallreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("hold%0d_update_pc", i), update_pc, 32'h500);
      check($sformatf("hold%0d_pred_flag", i), 32'(pred_flag), 32'd1);
      check($sformatf("hold%0d_q_count", i), 32'(q_count), 32'd1);
      tick();
    end
    stallreq = 1'b0;
    check("hold_release_q_count", 32'(q_count), 32'd1);
    tick();
    check("hold_popped_q_count", 32'(q_count), 32'd0);

    // flush with a concurrent new report
    stallreq = 1'b1;
    set0(32'h700, 1'b1, 1'b0, 32'h0, 1'b0); set1(32'h704, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(); idle();
    set0(32'h708, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    check("preflush_q_count", 32'(q_count), 32'd3);
    check("preflush_pred_flag", 32'(pred_flag), 32'd1);
    flush = 1'b1;
    set0(32'h7FC, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    check("flush_pred_flag", 32'(pred_flag), 32'd0);
    check("flush_pred_true", 32'(pred_true), 32'd0);
    tick();
    flush = 1'b0; idle(); stallreq = 1'b0;
    #1;
    check("postflush_q_count", 32'(q_count), 32'd0);
    check("postflush_overflow", 32'(overflow), 32'd1);
    check("postflush_pred_flag", 32'(pred_flag), 32'd0);
    check("postflush_pred_true", 32'(pred_true), 32'd0);
    check("postflush_in_ready", 32'(in_ready), 32'd1);

    // wrap-around: push one and pop one every cycle
    for (int i = 0; i < 20; i++) begin
      set0(32'h8000 + 32'(4 * i), 1'(i % 2), 1'b0, 32'h9000 + 32'(i), 1'b0);
      tick();
      check($sformatf("wrap%0d_update_pc", i), update_pc, 32'h8000 + 32'(4 * i));
      check($sformatf("wrap%0d_real_address", i), real_address, 32'h9000 + 32'(i));
      check($sformatf("wrap%0d_pred_flag", i), 32'(pred_flag), 32'(i % 2));
      check($sformatf("wrap%0d_q_count", i), 32'(q_count), 32'd1);
    end
    idle();
    tick();
    check("wrap_end_q_count", 32'(q_count), 32'd0);

    // asynchronous reset mid-stream
    set0(32'hA000, 1'b1, 1'b1, 32'hB000, 1'b1);
    tick(); idle();
    check("prereset_q_count", 32'(q_count), 32'd1);
    check("prereset_pred_flag", 32'(pred_flag), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_q_count", 32'(q_count), 32'd0);
    check("async_rst_pred_flag", 32'(pred_flag), 32'd0);
    check("async_rst_update_pc", update_pc, 32'h0);
    check("async_rst_overflow", 32'(overflow), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    #3 resetn = 1'b1;
    tick();
    check("after_rst_q_count", 32'(q_count), 32'd0);
    check("after_rst_pred_true", 32'(pred_true), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btb_update_queue.md
# btb_update_queue

Buffers branch-resolution reports from the two execute pipes (up to two per cycle) and feeds them, one per cycle and in program order, into the single update port of the branch target buffer. Updates are held while the BTB is stalled and are discarded on a pipeline flush. The block sits between the execute-stage branch units and the BTB. It owns the BTB update signals `update_pc`, `pred_flag`, `pred_true`, `real_direct`, `real_address` and `update_type`.

## Interface
- DEPTH, 4: number of queue entries. Must be a power of two and at least 2.
- CW, $clog2(DEPTH)+1: width of the occupancy counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- stallreq  in  1  BTB stall. While high, the head entry is not consumed.
- flush  in  1  pipeline flush. Empties the queue.
- in0_valid / in1_valid  in  1  resolution report valid. in0 is the older report.
- in0_pc / in1_pc  in  32  PC of the resolved branch.
- in0_mispred / in1_mispred  in  1  1 = the prediction was wrong.
- in0_taken / in1_taken  in  1  actual branch direction.
- in0_target / in1_target  in  32  actual target address.
- in0_type / in1_type  in  1  1 = unconditional (jump/call/return).
- in_ready  out  1  high when at least 2 entries are free.
- update_pc  out  32  PC of the head entry.
- pred_flag  out  1  head entry is valid and was mispredicted.
- pred_true  out  1  head entry is valid and was correctly predicted.
- real_direct  out  1  `taken` bit of the head entry.
- real_address  out  32  `target` of the head entry.
- update_type  out  1  `type` of the head entry.
- q_count  out  CW  current occupancy.
- overflow  out  1  sticky error flag. Set when a valid report is dropped.

## Operation
- Storage is a circular buffer of DEPTH entries, 67 bits each: {pc, mispred, taken, target, type}. It is managed by a write pointer `wp`, a read pointer `rp` and `count`. Both pointers wrap modulo DEPTH.
- **Enqueue** (no flush, and in_ready high at the clock edge):
  - Both valid: in0 is written at wp, in1 at wp+1, wp advances 2.
  - Only one valid: that report is written at wp, wp advances 1.
  - Program order is preserved even when both reports target the same BTB index; no merging.
- **Drop:** if in_ready is low and either valid is high, no report is written. `overflow` is set and stays set until reset.
- **Dequeue:** occurs when count != 0, stallreq = 0 and flush = 0. rp advances 1 and the BTB consumes the head entry on the same edge.
- **Counter:** next count = count + pushes − pop. Push and pop in the same cycle are legal. The result never exceeds DEPTH because in_ready guarantees room for 2.
- **in_ready** = (DEPTH − count) >= 2, computed from registered count only. A same-cycle pop does not make room.
- **Update strobes:**
  - pred_flag = (count != 0) & ~flush & head.mispred.
  - pred_true = (count != 0) & ~flush & ~head.mispred.
  - They are never both high.
- **Data outputs** (update_pc, real_direct, real_address, update_type) always show the head entry's fields, even when the queue is empty.
- **Flush:**
  - Takes priority over push and pop in the same cycle.
  - Next state: count = 0, wp = rp = 0. Inputs in that cycle are discarded.
  - No overflow is flagged for reports discarded by flush.
- **Reset:**
  - State: count = 0, wp = rp = 0, all entries 0, overflow = 0.
  - Outputs: pred_flag = pred_true = 0, update_pc = real_address = 0, real_direct = update_type = 0, q_count = 0, in_ready = 1.
  - Assertion mid-operation discards all entries immediately, without waiting for a clock edge.

## Timing
- Enqueue-to-update latency is one cycle. A report accepted at edge N appears on the update outputs during cycle N+1, when the queue was empty.
- No same-cycle bypass from the input ports to the update outputs.
- Throughput: one update per unstalled cycle. Sustained two reports per cycle fills the queue; in_ready then falls until drained.
- Outputs are driven from registers only, except for the flush gating of pred_flag/pred_true.
- stallreq high for K cycles holds the same head entry on the outputs for K cycles. Inputs keep enqueuing while in_ready is high.

## Test plan
- **Single report, ordered dual report:**
  - Single: reset, then in0 {pc=0x1000, mispred=1, taken=1, target=0x2000, type=0}. Cycle +1: pred_flag=1, update_pc=0x1000, real_address=0x2000. Cycle +2: pred_flag=0, q_count=0.
  - Dual: in0 pc=0x100 and in1 pc=0x104 in the same cycle. Updates for 0x100 then 0x104 appear on consecutive cycles, with pred_true or pred_flag matching each report's mispred bit.
- **Fill and overflow:** DEPTH=4, two reports per cycle for 3 cycles with stallreq=1.
  - in_ready falls after the 2nd push (count=4).
  - The 3rd pair is dropped and overflow=1.
  - Release stall: exactly 4 updates are issued in order.
- **Stall hold:** stallreq high for 3 cycles with one entry queued. Outputs stay constant and q_count stays 1. The entry pops on the first cycle with stallreq low.
- **Flush:** 3 entries queued, then flush together with a new in0 valid.
  - Same cycle: pred_flag = pred_true = 0.
  - Next cycle: q_count=0, overflow unchanged, no update issued.
- **Wrap-around and mid-run reset:**
  - 20 single reports with pop each cycle: pointers wrap several times with no loss or reorder.
  - Deassert resetn mid-stream: q_count=0 and pred_flag=0 immediately, without a clock edge.
